// File: rtl/regfile_dbg_if.sv
// Bus bundle for regfile_dbg: write port, two read ports and the debug dump stream.
// The master side drives requests; the slave side (the register file) returns data.
interface regfile_dbg_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              dbg_start;
  logic              dbg_busy;
  logic              dbg_valid;
  logic              dbg_ready;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic              dbg_last;

  modport master (
    output we, waddr, wdata, raddr1, raddr2, dbg_start, dbg_ready,
    input  rdata1, rdata2, dbg_busy, dbg_valid, dbg_addr, dbg_data, dbg_last
  );

  modport slave (
    input  we, waddr, wdata, raddr1, raddr2, dbg_start, dbg_ready,
    output rdata1, rdata2, dbg_busy, dbg_valid, dbg_addr, dbg_data, dbg_last
  );
endinterface

// File: rtl/regfile_dbg.sv
// 2-read/1-write register file with async clear, optional zero register and a
// valid/ready debug dump engine. Define WRITE_FORWARD_EN for write-to-read bypass.
module regfile_dbg #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  regfile_dbg_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              wr_en;
  logic              handshake;

  assign wr_en     = bus.we && !(ZERO_REG && (bus.waddr == '0));
  assign handshake = bus.dbg_valid && bus.dbg_ready;
  assign bus.dbg_busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  // The zero-register override is applied last so it beats any bypass.
  always_comb begin
    bus.rdata1 = mem[bus.raddr1];
    bus.rdata2 = mem[bus.raddr2];
`ifdef WRITE_FORWARD_EN
    if (bus.we && (bus.raddr1 == bus.waddr)) bus.rdata1 = bus.wdata;
    if (bus.we && (bus.raddr2 == bus.waddr)) bus.rdata2 = bus.wdata;
`endif
    if (ZERO_REG && (bus.raddr1 == '0)) bus.rdata1 = '0;
    if (ZERO_REG && (bus.raddr2 == '0)) bus.rdata2 = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.dbg_start) state_next = FETCH;
      FETCH:   state_next = SEND;
      SEND:    if (handshake) state_next = bus.dbg_last ? IDLE : FETCH;
      default: state_next = IDLE;
    endcase
  end

  // Beat fields are captured once in FETCH and held untouched through SEND.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx           <= '0;
      bus.dbg_valid <= 1'b0;
      bus.dbg_addr  <= '0;
      bus.dbg_data  <= '0;
      bus.dbg_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.dbg_start) idx <= '0;
        end
        FETCH: begin
          bus.dbg_data  <= mem[idx];
          bus.dbg_addr  <= idx;
          bus.dbg_last  <= (idx == '1);
          bus.dbg_valid <= 1'b1;
        end
        SEND: begin
          if (handshake) begin
            bus.dbg_valid <= 1'b0;
            if (!bus.dbg_last) idx <= idx + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
